// File: rtl/stage5_control_fsm.sv
// Multicycle control FSM for the stage-5 stack datapath: fetch/decode plus the
// per-state write, select and reset strobes for PC, MSP/RSP, memory and ValA/ValB/IR.
module stage5_control_fsm #(
    parameter int unsigned OPW      = 4,
    parameter int unsigned INIT_CYC = 1
) (
    input  logic        CLK,
    input  logic        RegResetN,
    input  logic        Start,
    input  logic [15:0] IROut,
    output logic        PCWrite,
    output logic        PCSource,
    output logic        PCAdd,
    output logic        PCRegReset,
    output logic        MSPWrite,
    output logic        MSPPop,
    output logic        MSPRegReset,
    output logic        RSPWrite,
    output logic        RSPPop,
    output logic        RSPRegReset,
    output logic        ValAWrite,
    output logic        ValBWrite,
    output logic        IRWrite,
    output logic        MemRead1,
    output logic        MemRead2,
    output logic        MemWrite1,
    output logic        MemWrite2,
    output logic [1:0]  MemDst1,
    output logic [1:0]  MemDst2,
    output logic [1:0]  MemData,
    output logic        Busy,
    output logic        Halted,
    output logic        IllegalOp
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_IDLE   = 4'd1,
        S_FETCH  = 4'd2,
        S_DECODE = 4'd3,
        S_PUSH1  = 4'd4,
        S_PUSH2  = 4'd5,
        S_POP1   = 4'd6,
        S_ALU1   = 4'd7,
        S_ALU2   = 4'd8,
        S_ALU3   = 4'd9,
        S_BR1    = 4'd10,
        S_JMP1   = 4'd11,
        S_JMP2   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam int unsigned CW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

    localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_PUSH = OPW'(1);
    localparam logic [OPW-1:0] OP_POP  = OPW'(2);
    localparam logic [OPW-1:0] OP_ALU  = OPW'(3);
    localparam logic [OPW-1:0] OP_BR   = OPW'(4);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(5);
    localparam logic [OPW-1:0] OP_HALT = '1;

    state_t          state, stateNext;
    logic [CW-1:0]   initCnt;
    logic [OPW-1:0]  opcode;
    logic            opLegal;
    logic            unusedIrBits;

    assign opcode       = IROut[15 -: OPW];
    assign unusedIrBits = ^IROut[15-OPW:0];

    always_ff @(posedge CLK or negedge RegResetN) begin
        if (!RegResetN) begin
            state   <= S_INIT;
            initCnt <= '0;
        end else begin
            state   <= stateNext;
            initCnt <= (state == S_INIT) ? initCnt + 1'b1 : '0;
        end
    end

    always_comb begin
        opLegal = 1'b1;
        case (opcode)
            OP_NOP, OP_PUSH, OP_POP, OP_ALU, OP_BR, OP_JMP, OP_HALT: opLegal = 1'b1;
            default: opLegal = 1'b0;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_INIT:   if (initCnt == CW'(INIT_CYC - 1)) stateNext = S_IDLE;
            S_IDLE:   if (Start) stateNext = S_FETCH;
            S_FETCH:  stateNext = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_PUSH: stateNext = S_PUSH1;
                    OP_POP:  stateNext = S_POP1;
                    OP_ALU:  stateNext = S_ALU1;
                    OP_BR:   stateNext = S_BR1;
                    OP_JMP:  stateNext = S_JMP1;
                    OP_HALT: stateNext = S_HALT;
                    default: stateNext = S_FETCH;
                endcase
            end
            S_PUSH1:  stateNext = S_PUSH2;
            S_PUSH2:  stateNext = S_FETCH;
            S_POP1:   stateNext = S_FETCH;
            S_ALU1:   stateNext = S_ALU2;
            S_ALU2:   stateNext = S_ALU3;
            S_ALU3:   stateNext = S_FETCH;
            S_BR1:    stateNext = S_FETCH;
            S_JMP1:   stateNext = S_JMP2;
            S_JMP2:   stateNext = S_FETCH;
            S_HALT:   if (Start) stateNext = S_FETCH;
            default:  stateNext = S_INIT;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCSource    = 1'b0;
        PCAdd       = 1'b0;
        PCRegReset  = 1'b0;
        MSPWrite    = 1'b0;
        MSPPop      = 1'b0;
        MSPRegReset = 1'b0;
        RSPWrite    = 1'b0;
        RSPPop      = 1'b0;
        RSPRegReset = 1'b0;
        ValAWrite   = 1'b0;
        ValBWrite   = 1'b0;
        IRWrite     = 1'b0;
        MemRead1    = 1'b0;
        MemRead2    = 1'b0;
        MemWrite1   = 1'b0;
        MemWrite2   = 1'b0;
        MemDst1     = 2'd0;
        MemDst2     = 2'd0;
        MemData     = 2'd0;
        Busy        = 1'b1;
        Halted      = 1'b0;
        IllegalOp   = 1'b0;
        case (state)
            S_INIT: begin
                PCRegReset  = 1'b1;
                MSPRegReset = 1'b1;
                RSPRegReset = 1'b1;
                Busy        = 1'b0;
            end
            S_IDLE: Busy = 1'b0;
            S_FETCH: begin
                MemRead1 = 1'b1;
                IRWrite  = 1'b1;
                PCWrite  = 1'b1;
            end
            // IR is a register, so this decode stays stable for the whole cycle
            S_DECODE: IllegalOp = ~opLegal;
            S_PUSH1:  MSPWrite = 1'b1;
            S_PUSH2: begin
                MemWrite1 = 1'b1;
                MemDst1   = 2'd1;
                MemData   = 2'd2;
            end
            S_POP1: begin
                MSPWrite = 1'b1;
                MSPPop   = 1'b1;
            end
            S_ALU1, S_JMP1: begin
                MemRead1  = 1'b1;
                MemDst1   = 2'd1;
                ValAWrite = 1'b1;
                MSPWrite  = 1'b1;
                MSPPop    = 1'b1;
            end
            S_ALU2: begin
                MemRead2  = 1'b1;
                ValBWrite = 1'b1;
            end
            S_ALU3: begin
                MemWrite2 = 1'b1;
                MemData   = 2'd1;
            end
            S_BR1: begin
                PCWrite = 1'b1;
                PCAdd   = 1'b1;
            end
            S_JMP2: begin
                PCWrite  = 1'b1;
                PCSource = 1'b1;
            end
            S_HALT: begin
                Busy   = 1'b0;
                Halted = 1'b1;
            end
            default: Busy = 1'b0;
        endcase
    end

endmodule
